// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and serial line levels.
// Used by uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset (both flops load RESET_VAL)
//   d      in   asynchronous input
//   q      out  synchronized output, two clk of latency
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, OVERSAMPLE x baud sampling via clk_en tick.
// Recovers LSB-first frames, rejects start-bit glitches, flags framing errors.
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   clk_en     in   oversample tick (1-clk pulse, OVERSAMPLE x baud)
//   rx         in   asynchronous serial input, idle high
//   data       out  last good byte, held until the next good frame
//   valid      out  1-clk pulse: data updated with a good frame
//   frame_err  out  1-clk pulse: stop bit sampled low
//   busy       out  high whenever the receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);

  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_t            state, state_next;
  logic                 rx_s;
  logic [SW-1:0]        samp_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_ok;
  logic                 stop_bad;

  sync_2ff #(.RESET_VAL(LINE_IDLE)) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Next-state and stop-bit decode; all transitions gated by clk_en.
  always_comb begin
    state_next = state;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    if (clk_en) begin
      case (state)
        ST_IDLE: begin
          if (rx_s == START_BIT) state_next = ST_START;
        end
        ST_START: begin
          // Half a bit in: a start bit still low is real, otherwise a glitch.
          if (samp_cnt == HALF_LAST)
            state_next = (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
        end
        ST_DATA: begin
          if (samp_cnt == SAMP_LAST && bit_cnt == BIT_LAST) state_next = ST_STOP;
        end
        ST_STOP: begin
          if (samp_cnt == SAMP_LAST) begin
            if (rx_s == STOP_BIT) begin
              stop_ok    = 1'b1;
              state_next = ST_IDLE;
            end else begin
              stop_bad   = 1'b1;
              state_next = ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          // Wait for the line to return high so a held-low line never retriggers.
          if (rx_s == LINE_IDLE) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (clk_en) begin
      case (state)
        ST_START: begin
          if (samp_cnt == HALF_LAST) begin
            samp_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            samp_cnt <= samp_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (samp_cnt == SAMP_LAST) begin
            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
            samp_cnt <= '0;
            if (bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + 1'b1;
          end else begin
            samp_cnt <= samp_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (samp_cnt == SAMP_LAST) samp_cnt <= '0;
          else                       samp_cnt <= samp_cnt + 1'b1;
        end
        default: samp_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= stop_ok;
      frame_err <= stop_bad;
      if (stop_ok) data <= shreg;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (OVERSAMPLE=16, clk_en every 4 clk).
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_en = 1'b0;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_valid_cyc = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Tick generator and output monitor, both on the inactive edge.
  always @(negedge clk) begin
    cyc++;
    clk_en = (cyc % 4 == 0);
    if (rst_n === 1'b1) begin
      if (valid === 1'b1) begin
        got_q.push_back(data);
        last_valid_cyc = cyc;
      end
      if (frame_err === 1'b1) ferr_cnt++;
      if (valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bt);
    start_cyc = cyc;
    drive(1'b0, bt);
    for (int i = 0; i < 8; i++) drive(b[i], bt);
    drive(stop, bt);
    rx = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(n < 2000), 32'd1);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_frames(input string tag, input int exp_ferr);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_data"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_ferr"}, 32'(ferr_cnt), 32'(exp_ferr));
    got_q.delete();
    exp_q.delete();
    ferr_cnt = 0;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] prev;
    int lat;

    rst_n = 1'b0;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_data", 32'(data), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_ferr", 32'(frame_err), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Single frame plus latency from start edge to valid.
    send_frame(8'hA5, 1'b1, BIT_CLK);
    exp_q.push_back(8'hA5);
    wait_idle("a5");
    lat = last_valid_cyc - start_cyc;
    chk("latency", 32'(lat >= 606 && lat <= 618), 32'd1);
    check_frames("a5", 0);

    // Extremes then back-to-back with no idle gap.
    send_frame(8'h00, 1'b1, BIT_CLK); exp_q.push_back(8'h00);
    send_frame(8'hFF, 1'b1, BIT_CLK); exp_q.push_back(8'hFF);
    send_frame(8'h55, 1'b1, BIT_CLK); exp_q.push_back(8'h55);
    send_frame(8'hAA, 1'b1, BIT_CLK); exp_q.push_back(8'hAA);
    wait_idle("b2b");
    check_frames("b2b", 0);

    // Start glitch of 4 ticks, then a real frame.
    drive(1'b0, 16);
    drive(1'b1, 100);
    chk("glitch_busy", 32'(busy), 32'h0);
    chk("glitch_nout", 32'(got_q.size() + ferr_cnt), 32'd0);
    send_frame(8'h3C, 1'b1, BIT_CLK); exp_q.push_back(8'h3C);
    wait_idle("glitch");
    check_frames("glitch", 0);

    // Random frames with random gaps and +/-3% bit-time skew.
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 62 + 2 * int'($urandom_range(0, 2)));
      exp_q.push_back(b);
      repeat ($urandom_range(0, 100)) @(negedge clk);
    end
    wait_idle("rand");
    check_frames("rand", 0);

    // Explicit skew cases.
    send_frame(8'hC3, 1'b1, 62); exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 66); exp_q.push_back(8'hC3);
    wait_idle("skew");
    check_frames("skew", 0);

    // Framing error: stop bit low, line held low for 40 ticks.
    prev = 8'h80 | 8'($urandom);
    send_frame(prev, 1'b1, BIT_CLK); exp_q.push_back(prev);
    wait_idle("pre_err");
    check_frames("pre_err", 0);
    send_frame(8'h3C, 1'b0, BIT_CLK);
    drive(1'b0, 160);
    chk("err_busy_low", 32'(busy), 32'h1);
    rx = 1'b1;
    wait_idle("err");
    chk("err_data_kept", 32'(data), 32'(prev));
    check_frames("err", 1);

    // Reset in the middle of a frame.
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive(i == 0 ? 1'b1 : 1'b0, BIT_CLK);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_data", 32'(data), 32'h0);
    chk("midrst_valid", 32'(valid), 32'h0);
    chk("midrst_ferr", 32'(frame_err), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h81, 1'b1, BIT_CLK); exp_q.push_back(8'h81);
    wait_idle("post_rst");
    check_frames("post_rst", 0);
    chk("post_rst_data", 32'(data), 32'h81);

    chk("never_both", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
